key_debounce_pulse: RTL and testbench

Conditions one raw push-button input into clean, single-clock control strobes for the counter stage downstream. The block synchronises the asynchronous key into the clock domain and debounces it with a stable-level counter. It emits a one-cycle `press_pulse` that drives the modulo-k counter's `enable`, so each physical key press advances the count by exactly one. It also provides a debounced level and a release strobe for other board-level logic.

---
 rtl/key_debounce_pulse.sv | 141 ++++++++++++++
 tb/tb_key_debounce_pulse.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_pulse.sv
// Push-button conditioner: two-flop synchroniser, stable-level debounce FSM, one-cycle press/release strobes.
// Optional auto-repeat of press_pulse while held is enabled by defining KEY_DEBOUNCE_AUTOREPEAT_EN.
module key_debounce_pulse #(
  parameter int DEBOUNCE      = 50000,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       i_clk,
  input  logic       i_sclr,
  input  logic       i_key_in,
  output logic       o_key_level,
  output logic       o_press_pulse,
  output logic       o_release_pulse,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam int             CW      = $clog2(DEBOUNCE);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE - 1);

  if (DEBOUNCE < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY)
  begin : g_param_check
    $error("key_debounce_pulse: invalid parameter set");
  end

  // Normalise before the synchroniser so both flops reset to the released level (0).
  logic w_key_norm;
  assign w_key_norm = (ACTIVE_LOW != 0) ? ~i_key_in : i_key_in;

  logic          r_s1;
  logic          r_s2;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_key_level;
  logic          r_press;
  logic          r_release;

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam int             RW       = $clog2(REPEAT_DELAY);
  localparam logic [RW-1:0]  RPT_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]  RPT_RELD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [RW-1:0] r_rcnt;
`endif

  always_ff @(posedge i_clk) begin
    if (i_sclr) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= w_key_norm;
      r_s2 <= r_s1;
    end
  end

  // Level check always precedes the count check, so a bounce on the terminal count aborts acceptance.
  always_ff @(posedge i_clk) begin
    if (i_sclr) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_key_level <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
      r_rcnt      <= '0;
`endif
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_s2) begin
            r_state <= WAIT_PRESS;
            r_cnt   <= '0;
          end
        end
        WAIT_PRESS: begin
          if (!r_s2) begin
            r_state <= IDLE;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            r_rcnt  <= '0;
`endif
          end else if (r_cnt == CNT_MAX) begin
            r_state     <= PRESSED;
            r_press     <= 1'b1;
            r_key_level <= 1'b1;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            r_rcnt      <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!r_s2) begin
            r_state <= WAIT_RELEASE;
            r_cnt   <= '0;
          end
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
          // Reloading to DELAY-PERIOD makes later repeats land every REPEAT_PERIOD cycles.
          else if (r_rcnt == RPT_LAST) begin
            r_press <= 1'b1;
            r_rcnt  <= RPT_RELD;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
`endif
        end
        WAIT_RELEASE: begin
          if (r_s2) begin
            r_state <= PRESSED;
          end else if (r_cnt == CNT_MAX) begin
            r_state     <= IDLE;
            r_release   <= 1'b1;
            r_key_level <= 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            r_rcnt      <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_key_level     = r_key_level;
  assign o_press_pulse   = r_press;
  assign o_release_pulse = r_release;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Self-checking bench for key_debounce_pulse (DEBOUNCE=4, active-low key); strobes are scoreboarded by edge number.
module tb_key_debounce_pulse;

  localparam int DEBOUNCE      = 4;
  localparam int REPEAT_DELAY  = 10;
  localparam int REPEAT_PERIOD = 3;
  localparam int LAT           = DEBOUNCE + 2;

  logic       clk;
  logic       sclr;
  logic       key_in;
  logic       key_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [1:0] dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Expected strobe: bit 31 = 1 for press, 0 for release; low bits = edge that registers it.
  logic [31:0] exp_q[$];
  logic [3:0]  cnt_q;

  key_debounce_pulse #(
    .DEBOUNCE     (DEBOUNCE),
    .ACTIVE_LOW   (1),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .i_clk          (clk),
    .i_sclr         (sclr),
    .i_key_in       (key_in),
    .o_key_level    (key_level),
    .o_press_pulse  (press_pulse),
    .o_release_pulse(release_pulse),
    .o_dbg_state    (dbg_state)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Downstream counter whose enable is press_pulse.
  always @(posedge clk) begin
    if (sclr) cnt_q <= '0;
    else if (press_pulse) cnt_q <= cnt_q + 4'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d, required finish earlier", cyc);
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ev(input logic is_press, input int edge_n);
    ev = {is_press, edge_n[30:0]};
  endfunction

  // ---- scoreboard: pop an expectation whenever the DUT produces a strobe ----
  always @(negedge clk) begin
    if (press_pulse || release_pulse) begin
      n_total++;
      if (press_pulse && release_pulse) begin
        $display("FAIL sb_both_strobes: edge %0d press=1 release=1, required at most one", cyc);
      end else if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: edge %0d press=%0b release=%0b, required no strobe",
                 cyc, press_pulse, release_pulse);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (ev(press_pulse, cyc) !== e)
          $display("FAIL sb_strobe: got press=%0b at edge %0d, required press=%0b at edge %0d",
                   press_pulse, cyc, e[31], e[30:0]);
        else n_pass++;
      end
    end
  end

  // ---- driver tasks ----
  task automatic wait_to(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic drive_key(input logic pressed, output int k);
    key_in = ~pressed;
    k = cyc + 1;
  endtask

  // ---- scenarios ----
  task automatic test_reset;
    sclr = 1'b1;
    key_in = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({key_level, press_pulse, release_pulse, dbg_state} !== 5'b0)
      $display("FAIL reset_outputs: level/press/release/state=%b, required 00000",
               {key_level, press_pulse, release_pulse, dbg_state});
    else n_pass++;
    sclr = 1'b0;
    repeat (4) @(negedge clk);
    n_total++;
    if ({key_level, dbg_state} !== 3'b0)
      $display("FAIL reset_idle_released: level/state=%b, required 000", {key_level, dbg_state});
    else n_pass++;
  endtask

  task automatic test_clean_press;
    int k;
    drive_key(1'b1, k);
    exp_q.push_back(ev(1'b1, k + LAT));
    wait_to(k + LAT - 1);
    n_total++;
    if (key_level !== 1'b0) $display("FAIL press_level_early: key_level=%0b, required 0", key_level);
    else n_pass++;
    wait_to(k + LAT);
    n_total++;
    if ({key_level, press_pulse} !== 2'b11)
      $display("FAIL press_edge: level/press=%b, required 11", {key_level, press_pulse});
    else n_pass++;
    wait_to(k + LAT + 1);
    n_total++;
    if ({key_level, press_pulse} !== 2'b10)
      $display("FAIL press_one_cycle: level/press=%b, required 10", {key_level, press_pulse});
    else n_pass++;
    drive_key(1'b0, k);
    exp_q.push_back(ev(1'b0, k + LAT));
    wait_to(k + LAT);
    n_total++;
    if ({key_level, release_pulse} !== 2'b01)
      $display("FAIL release_edge: level/release=%b, required 01", {key_level, release_pulse});
    else n_pass++;
    wait_to(k + LAT + 2);
    #1;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL clean_pending: %0d strobes missing, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_bounce_press;
    int k;
    int k2;
    drive_key(1'b1, k);
    wait_to(k + 2);
    drive_key(1'b0, k2);
    wait_to(k + 3);
    drive_key(1'b1, k2);
    exp_q.push_back(ev(1'b1, k2 + LAT));
    wait_to(k2 + LAT - 1);
    n_total++;
    if (key_level !== 1'b0) $display("FAIL bounce_level_early: key_level=%0b, required 0", key_level);
    else n_pass++;
    wait_to(k2 + LAT + 1);
    #1;
    n_total++;
    if (exp_q.size() != 0 || key_level !== 1'b1)
      $display("FAIL bounce_press: pending=%0d level=%0b, required 0 and 1", exp_q.size(), key_level);
    else n_pass++;
  endtask

  task automatic test_bounce_release;
    int k;
    int k2;
    drive_key(1'b0, k);
    wait_to(k + 1);
    drive_key(1'b1, k2);
    wait_to(k + 2);
    drive_key(1'b0, k2);
    exp_q.push_back(ev(1'b0, k2 + LAT));
    wait_to(k2 + LAT - 1);
    n_total++;
    if (key_level !== 1'b1) $display("FAIL relbounce_level_hold: key_level=%0b, required 1", key_level);
    else n_pass++;
    wait_to(k2 + LAT);
    n_total++;
    if ({key_level, release_pulse} !== 2'b01)
      $display("FAIL relbounce_edge: level/release=%b, required 01", {key_level, release_pulse});
    else n_pass++;
    wait_to(k2 + LAT + 2);
    #1;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL relbounce_pending: %0d missing, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_press;
    int k;
    drive_key(1'b1, k);
    exp_q.push_back(ev(1'b1, k + LAT));
    wait_to(k + LAT + 1);
    sclr = 1'b1;
    wait_to(k + LAT + 2);
    n_total++;
    if ({key_level, press_pulse, release_pulse, dbg_state} !== 5'b0)
      $display("FAIL midreset_outputs: level/press/release/state=%b, required 00000",
               {key_level, press_pulse, release_pulse, dbg_state});
    else n_pass++;
    sclr = 1'b0;
    k = cyc + 1;
    exp_q.push_back(ev(1'b1, k + LAT));
    wait_to(k + LAT);
    n_total++;
    if ({key_level, press_pulse} !== 2'b11)
      $display("FAIL midreset_repress: level/press=%b, required 11", {key_level, press_pulse});
    else n_pass++;
    drive_key(1'b0, k);
    exp_q.push_back(ev(1'b0, k + LAT));
    wait_to(k + LAT + 2);
    #1;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL midreset_pending: %0d missing, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_counter;
    int k;
    logic [3:0] q0;
    q0 = cnt_q;
    for (int i = 0; i < 5; i++) begin
      wait_to(cyc + $urandom_range(1, 4));
      drive_key(1'b1, k);
      exp_q.push_back(ev(1'b1, k + LAT));
      wait_to(k + LAT + 1);
      n_total++;
      if (cnt_q !== q0 + 4'(i + 1))
        $display("FAIL counter_step%0d: Q=%0d, required %0d", i, cnt_q, q0 + 4'(i + 1));
      else n_pass++;
      drive_key(1'b0, k);
      exp_q.push_back(ev(1'b0, k + LAT));
      wait_to(k + LAT + 1);
    end
    #1;
    n_total++;
    if (cnt_q - q0 !== 4'd5 || exp_q.size() != 0)
      $display("FAIL counter_total: delta=%0d pending=%0d, required 5 and 0", cnt_q - q0, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_auto_repeat;
    int k;
    int p;
    drive_key(1'b1, k);
    p = k + LAT;
    exp_q.push_back(ev(1'b1, p));
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    for (int d = REPEAT_DELAY; d <= 22; d += REPEAT_PERIOD) exp_q.push_back(ev(1'b1, p + d));
`endif
    wait_to(p + 22);
    drive_key(1'b0, k);
    exp_q.push_back(ev(1'b0, k + LAT));
    wait_to(k + 1);
    n_total++;
    if (key_level !== 1'b1) $display("FAIL repeat_level_held: key_level=%0b, required 1", key_level);
    else n_pass++;
    wait_to(k + LAT + 2);
    #1;
    n_total++;
    if (exp_q.size() != 0 || key_level !== 1'b0)
      $display("FAIL repeat_pending: pending=%0d level=%0b, required 0 and 0", exp_q.size(), key_level);
    else n_pass++;
  endtask

  // ---- sequence and final report ----
  initial begin
    sclr = 1'b1;
    key_in = 1'b1;
    test_reset;
    test_clean_press;
    test_bounce_press;
    test_bounce_release;
    test_reset_mid_press;
    test_counter;
    test_auto_repeat;
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
